// File: rtl/apb_slave_regfile.sv
// APB slave register file: parametrised width/depth, optional wait states,
// byte strobes, SLVERR on bad address or read-only write.
module apb_slave_regfile #(
    parameter int unsigned          AWIDTH      = 8,
    parameter int unsigned          DWIDTH      = 32,
    parameter int unsigned          NUM_REGS    = 16,
    parameter int unsigned          WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p_sel,
    input  logic                  p_en,
    input  logic                  p_write,
    input  logic [AWIDTH-1:0]     addr,
    input  logic [DWIDTH-1:0]     wdata,
    input  logic [DWIDTH/8-1:0]   p_strb,
    output logic [DWIDTH-1:0]     rdata,
    output logic                  p_ready,
    output logic                  p_slverr
);

    localparam int unsigned       NBYTES   = DWIDTH / 8;
    localparam int unsigned       OFFW     = (NBYTES > 1) ? $clog2(NBYTES) : 0;
    localparam int unsigned       IDXW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [AWIDTH-1:0] OFF_MASK = AWIDTH'(NBYTES - 1);
    localparam logic [3:0]        WS       = 4'(WAIT_STATES);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [DWIDTH-1:0] regs_q [NUM_REGS];
    logic [DWIDTH-1:0] regs_d [NUM_REGS];

    logic [AWIDTH-1:0] idx_full;
    logic [IDXW-1:0]   idx;
    logic              in_range;
    logic              err;

    // Address decode is purely combinational on the live bus signals.
    always_comb begin
        idx_full = addr >> OFFW;
        idx      = idx_full[IDXW-1:0];
        in_range = (32'(idx_full) < NUM_REGS);
        err      = (|(addr & OFF_MASK)) || !in_range || (p_write && RO_MASK[idx]);
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        regs_d     = regs_q;
        p_ready    = (state_q == ACCESS) && p_sel && p_en && (wait_cnt_q == WS);
        p_slverr   = p_ready && err;
        rdata      = '0;
        if (p_ready && !p_write && !err) begin
            rdata = regs_q[idx];
        end
        unique case (state_q)
            IDLE: begin
                if (p_sel && !p_en) begin
                    state_d    = ACCESS;
                    wait_cnt_d = '0;
                end
            end
            ACCESS: begin
                if (!p_sel) begin
                    state_d = IDLE;
                end else if (p_ready) begin
                    state_d = IDLE;
                    if (p_write && !err) begin
                        for (int unsigned b = 0; b < NBYTES; b++) begin
                            if (p_strb[b]) begin
                                regs_d[idx][b*8 +: 8] = wdata[b*8 +: 8];
                            end
                        end
                    end
                end else if (wait_cnt_q < WS) begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            regs_q     <= regs_d;
        end
    end

endmodule
